// File: rtl/hist_pkg.sv
// Shared state encoding, default widths and helpers for the pipelined histogram calculator.
package hist_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StErase,
        StWaitSof,
        StCollect,
        StDrain
    } hist_state_e;

    localparam int unsigned DRAIN_CYC    = 3;
    localparam int unsigned PIX_GOOD_BIT = 15;

    localparam int unsigned DEF_PIX_W  = 14;
    localparam int unsigned DEF_BIN_W  = 14;
    localparam int unsigned DEF_CNT_W  = 18;
    localparam int unsigned DEF_FCNT_W = 24;

    // All-ones value of a w-bit counter; callers truncate to their own width.
    function automatic logic [31:0] cnt_max(input int unsigned w);
        if (w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/hist_fwd_inc.sv
// S2 stage: picks the newest in-flight count for the bin (or the RAM value) and issues the
// saturating increment as the next RAM write.
module hist_fwd_inc
    import hist_pkg::*;
#(
    parameter int unsigned BIN_W = DEF_BIN_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             vld,
    input  logic [BIN_W-1:0] bin,
    input  logic [CNT_W-1:0] ram_dout,
    output logic             we,
    output logic [BIN_W-1:0] addr,
    output logic [CNT_W-1:0] din,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    // h1 is the write issued one cycle ago, h2 two cycles ago; neither is visible to the
    // RAM read that produced ram_dout yet.
    logic             h1_vld_q, h2_vld_q;
    logic [BIN_W-1:0] h1_bin_q, h2_bin_q;
    logic [CNT_W-1:0] h1_cnt_q, h2_cnt_q;
    logic [CNT_W-1:0] cnt;
    logic             at_max;

    always_comb begin
        cnt = ram_dout;
        if (h1_vld_q && (h1_bin_q == bin)) begin
            cnt = h1_cnt_q;
        end else if (h2_vld_q && (h2_bin_q == bin)) begin
            cnt = h2_cnt_q;
        end
    end

    assign at_max = (cnt == CNT_MAX);
    assign sat    = vld && at_max;
    assign din    = at_max ? CNT_MAX : cnt + CNT_W'(1);
    assign we     = vld;
    assign addr   = bin;

    always_ff @(posedge clk) begin
        if (srst) begin
            h1_vld_q <= 1'b0;
            h2_vld_q <= 1'b0;
        end else begin
            h1_vld_q <= vld;
            h2_vld_q <= h1_vld_q;
        end
    end

    always_ff @(posedge clk) begin
        h1_bin_q <= bin;
        h1_cnt_q <= din;
        h2_bin_q <= h1_bin_q;
        h2_cnt_q <= h1_cnt_q;
    end

endmodule

// File: rtl/hist_calc_pipe.sv
// Fully pipelined histogram accumulator: erase the external RAM, then count one frame of good
// pixels into saturating bins at one pixel per clock.
module hist_calc_pipe
    import hist_pkg::*;
#(
    parameter int unsigned PIX_W  = DEF_PIX_W,
    parameter int unsigned BIN_W  = DEF_BIN_W,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned FCNT_W = DEF_FCNT_W
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              sof,
    input  logic              hist_upd,
    output logic              hist_rdy,
    output logic [FCNT_W-1:0] frm_pix_cnt,
    output logic              sat_flag,
    input  logic [15:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [BIN_W-1:0]  ram_rd_addr,
    input  logic [CNT_W-1:0]  ram_rd_dout,
    output logic              ram_we,
    output logic [BIN_W-1:0]  ram_wr_addr,
    output logic [CNT_W-1:0]  ram_wr_din
);

    localparam int unsigned       DW         = $clog2(DRAIN_CYC);
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_CYC - 1);
    localparam logic [BIN_W-1:0]  BIN_LAST   = {BIN_W{1'b1}};
    localparam logic [FCNT_W-1:0] FCNT_MAX   = FCNT_W'(cnt_max(FCNT_W));

    hist_state_e       state_q, state_d;
    logic              hist_rdy_q, hist_rdy_d;
    logic              ram_we_q, ram_we_d;
    logic [BIN_W-1:0]  wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]  wr_din_q, wr_din_d;
    logic [BIN_W-1:0]  rd_addr_q;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [FCNT_W-1:0] frm_cnt_q, frm_cnt_d;
    logic              sat_acc_q, sat_acc_d;
    logic              sat_q, sat_d;

    logic              s1_vld_q, s2_vld_q;
    logic [BIN_W-1:0]  s1_bin_q, s2_bin_q;

    logic              accept;
    logic [BIN_W-1:0]  pix_bin;
    logic              fwd_we;
    logic [BIN_W-1:0]  fwd_addr;
    logic [CNT_W-1:0]  fwd_din;
    logic              fwd_sat;
    logic              unused_in;

    assign unused_in     = ^{s_axis_tlast, s_axis_tdata};
    assign pix_bin       = s_axis_tdata[PIX_W-1 -: BIN_W];
    assign s_axis_tready = (state_q != StErase) && (state_q != StDrain);
    // A pixel arriving together with sof belongs to neither frame.
    assign accept = (state_q == StCollect) && !sof && s_axis_tvalid
                    && s_axis_tdata[PIX_GOOD_BIT];

    hist_fwd_inc #(
        .BIN_W (BIN_W),
        .CNT_W (CNT_W)
    ) u_fwd_inc (
        .clk      (clk),
        .srst     (srst),
        .vld      (s2_vld_q),
        .bin      (s2_bin_q),
        .ram_dout (ram_rd_dout),
        .we       (fwd_we),
        .addr     (fwd_addr),
        .din      (fwd_din),
        .sat      (fwd_sat)
    );

    always_comb begin
        state_d     = state_q;
        hist_rdy_d  = hist_rdy_q;
        ram_we_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_din_d    = wr_din_q;
        drain_cnt_d = drain_cnt_q;
        fcnt_d      = fcnt_q;
        frm_cnt_d   = frm_cnt_q;
        sat_acc_d   = sat_acc_q;
        sat_d       = sat_q;

        unique case (state_q)
            StIdle: begin
                if (hist_upd) begin
                    state_d    = StErase;
                    hist_rdy_d = 1'b0;
                    ram_we_d   = 1'b1;
                    wr_addr_d  = '0;
                    wr_din_d   = '0;
                end
            end
            StErase: begin
                if (wr_addr_q == BIN_LAST) begin
                    state_d = StWaitSof;
                end else begin
                    ram_we_d  = 1'b1;
                    wr_addr_d = wr_addr_q + BIN_W'(1);
                end
            end
            StWaitSof: begin
                if (sof) begin
                    state_d   = StCollect;
                    fcnt_d    = '0;
                    sat_acc_d = 1'b0;
                end
            end
            StCollect: begin
                if (sof) begin
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end
            end
            StDrain: begin
                // DRAIN_CYC covers the S1/S2 stages plus the final write cycle.
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d    = StIdle;
                    hist_rdy_d = 1'b1;
                    frm_cnt_d  = fcnt_q;
                    sat_d      = sat_acc_q;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (fwd_we) begin
            ram_we_d  = 1'b1;
            wr_addr_d = fwd_addr;
            wr_din_d  = fwd_din;
            sat_acc_d = sat_acc_q | fwd_sat;
            if (fcnt_q != FCNT_MAX) begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= StIdle;
            hist_rdy_q  <= 1'b1;
            ram_we_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_din_q    <= '0;
            rd_addr_q   <= '0;
            drain_cnt_q <= '0;
            fcnt_q      <= '0;
            frm_cnt_q   <= '0;
            sat_acc_q   <= 1'b0;
            sat_q       <= 1'b0;
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_rdy_q  <= hist_rdy_d;
            ram_we_q    <= ram_we_d;
            wr_addr_q   <= wr_addr_d;
            wr_din_q    <= wr_din_d;
            drain_cnt_q <= drain_cnt_d;
            fcnt_q      <= fcnt_d;
            frm_cnt_q   <= frm_cnt_d;
            sat_acc_q   <= sat_acc_d;
            sat_q       <= sat_d;
            s1_vld_q    <= accept;
            s2_vld_q    <= s1_vld_q;
            if (accept) begin
                rd_addr_q <= pix_bin;
            end
        end
    end

    always_ff @(posedge clk) begin
        s1_bin_q <= pix_bin;
        s2_bin_q <= s1_bin_q;
    end

    assign hist_rdy    = hist_rdy_q;
    assign frm_pix_cnt = frm_cnt_q;
    assign sat_flag    = sat_q;
    assign ram_rd_addr = rd_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_din  = wr_din_q;

endmodule

// File: tb/tb_hist_calc_pipe.sv
// Scoreboard bench for hist_calc_pipe with a small dual-port RAM model (BIN_W=CNT_W=4).
module tb_hist_calc_pipe;

    localparam int unsigned PIX_W  = 4;
    localparam int unsigned BIN_W  = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned FCNT_W = 8;

    logic              clk = 1'b0;
    logic              srst = 1'b1;
    logic              sof = 1'b0;
    logic              hist_upd = 1'b0;
    logic              hist_rdy;
    logic [FCNT_W-1:0] frm_pix_cnt;
    logic              sat_flag;
    logic [15:0]       s_axis_tdata = 16'h0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic              s_axis_tlast = 1'b0;
    logic [BIN_W-1:0]  ram_rd_addr;
    logic [CNT_W-1:0]  ram_rd_dout;
    logic              ram_we;
    logic [BIN_W-1:0]  ram_wr_addr;
    logic [CNT_W-1:0]  ram_wr_din;

    int checks = 0;
    int errors = 0;

    logic [7:0] wr_q[$];   // expected writes {addr, din}
    logic [8:0] res_q[$];  // expected frame results {sat_flag, frm_pix_cnt}
    logic [3:0] mem[16];
    logic [3:0] mdl[16];
    logic [3:0] want[16];
    logic       prefill = 1'b0;

    always #5 clk = ~clk;

    hist_calc_pipe #(
        .PIX_W  (PIX_W),
        .BIN_W  (BIN_W),
        .CNT_W  (CNT_W),
        .FCNT_W (FCNT_W)
    ) dut (
        .clk           (clk),
        .srst          (srst),
        .sof           (sof),
        .hist_upd      (hist_upd),
        .hist_rdy      (hist_rdy),
        .frm_pix_cnt   (frm_pix_cnt),
        .sat_flag      (sat_flag),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .ram_rd_addr   (ram_rd_addr),
        .ram_rd_dout   (ram_rd_dout),
        .ram_we        (ram_we),
        .ram_wr_addr   (ram_wr_addr),
        .ram_wr_din    (ram_wr_din)
    );

    // Read-first, latency-1 simple dual-port RAM.
    always @(posedge clk) begin
        ram_rd_dout <= mem[ram_rd_addr];
        if (prefill) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'hF;
        end else if (ram_we) begin
            mem[ram_wr_addr] <= ram_wr_din;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes RAM or publishes a frame result.
    initial begin : monitor
        logic       prev_rdy;
        logic       prev_srst;
        logic [7:0] w;
        logic [8:0] r;
        prev_rdy  = 1'b1;
        prev_srst = 1'b1;
        forever begin
            @(negedge clk);
            if (ram_we === 1'b1) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected got addr %0h din %0h expected no write",
                             ram_wr_addr, ram_wr_din);
                end else begin
                    w = wr_q.pop_front();
                    if ({ram_wr_addr, ram_wr_din} !== w) begin
                        errors++;
                        $display("FAIL wr got addr %0h din %0h expected addr %0h din %0h",
                                 ram_wr_addr, ram_wr_din, w[7:4], w[3:0]);
                    end
                end
            end
            if (hist_rdy === 1'b1 && prev_rdy === 1'b0 && prev_srst !== 1'b1) begin
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_unexpected got cnt %0d sat %0d", frm_pix_cnt, sat_flag);
                end else begin
                    r = res_q.pop_front();
                    if ({sat_flag, frm_pix_cnt} !== r) begin
                        errors++;
                        $display("FAIL result got cnt %0d sat %0d expected cnt %0d sat %0d",
                                 frm_pix_cnt, sat_flag, r[7:0], r[8]);
                    end
                end
            end
            prev_rdy  = hist_rdy;
            prev_srst = srst;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic erase();
        hist_upd = 1'b1;
        cyc();
        hist_upd = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_q.push_back({4'(i), 4'h0});
            mdl[i] = 4'h0;
            chk("erase_we", 32'(ram_we), 32'd1);
            chk("erase_tready", 32'(s_axis_tready), 32'd0);
            chk("erase_rdy", 32'(hist_rdy), 32'd0);
            cyc();
        end
        chk("erase_end_we", 32'(ram_we), 32'd0);
        chk("wait_sof_tready", 32'(s_axis_tready), 32'd1);
    endtask

    // One stimulus cycle; counted pixels update the model and queue the expected write.
    task automatic px(input logic [15:0] d, input logic v, input bit counted);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        chk("tready", 32'(s_axis_tready), 32'd1);
        if (counted) begin
            if (mdl[d[3:0]] != 4'hF) mdl[d[3:0]] = mdl[d[3:0]] + 4'h1;
            wr_q.push_back({d[3:0], mdl[d[3:0]]});
        end
        cyc();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic open_frame();
        sof = 1'b1;
        px(16'h8004, 1'b1, 1'b0);
        sof = 1'b0;
    endtask

    task automatic close_frame(input int cnt, input bit sat);
        res_q.push_back({sat, 8'(cnt)});
        sof = 1'b1;
        px(16'h8003, 1'b1, 1'b0);
        sof = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_rdy", 32'(hist_rdy), 32'd0);
            chk("drain_tready", 32'(s_axis_tready), 32'd0);
            cyc();
        end
        chk("rdy_after_drain", 32'(hist_rdy), 32'd1);
        chk("idle_tready", 32'(s_axis_tready), 32'd1);
    endtask

    task automatic ram_check();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ram[%0d]", i), 32'(mem[i]), 32'(want[i]));
        end
    endtask

    initial begin : stim
        int seq[7] = '{5, 6, 5, 5, 6, 7, 5};
        prefill = 1'b1;
        repeat (3) cyc();
        chk("rst_hist_rdy", 32'(hist_rdy), 32'd1);
        chk("rst_tready", 32'(s_axis_tready), 32'd1);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
        chk("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
        chk("rst_wr_din", 32'(ram_wr_din), 32'd0);
        chk("rst_frm_cnt", 32'(frm_pix_cnt), 32'd0);
        chk("rst_sat", 32'(sat_flag), 32'd0);
        prefill = 1'b0;
        srst    = 1'b0;
        px(16'h8001, 1'b1, 1'b0);  // discarded in IDLE

        // Back-to-back same bin.
        erase();
        open_frame();
        for (int i = 0; i < 10; i++) px(16'h8003, 1'b1, 1'b1);
        close_frame(10, 1'b0);
        want = '{default: 4'h0};
        want[3] = 4'd10;
        ram_check();

        // Read-modify-write hazards at full rate.
        erase();
        open_frame();
        for (int i = 0; i < 7; i++) px(16'h8000 | 16'(seq[i]), 1'b1, 1'b1);
        close_frame(7, 1'b0);
        want = '{default: 4'h0};
        want[5] = 4'd4;
        want[6] = 4'd2;
        want[7] = 4'd1;
        ram_check();

        // Saturation.
        erase();
        open_frame();
        for (int i = 0; i < 20; i++) px(16'h8002, 1'b1, 1'b1);
        close_frame(20, 1'b1);
        want = '{default: 4'h0};
        want[2] = 4'hF;
        ram_check();

        // Filtering, framing, tvalid gaps, and hist_upd ignored mid-frame.
        erase();
        px(16'h8001, 1'b1, 1'b0);
        px(16'h8002, 1'b1, 1'b0);
        open_frame();
        px(16'h8008, 1'b1, 1'b1);
        px(16'h0008, 1'b1, 1'b0);
        px(16'h8009, 1'b0, 1'b0);
        hist_upd = 1'b1;
        px(16'h8009, 1'b1, 1'b1);
        hist_upd = 1'b0;
        px(16'h0009, 1'b1, 1'b0);
        px(16'h0000, 1'b0, 1'b0);
        px(16'h8008, 1'b1, 1'b1);
        close_frame(3, 1'b0);
        want = '{default: 4'h0};
        want[8] = 4'd2;
        want[9] = 4'd1;
        ram_check();

        // Reset with two pixels in flight; their writes must never appear.
        erase();
        open_frame();
        px(16'h8005, 1'b1, 1'b0);
        px(16'h8006, 1'b1, 1'b0);
        srst = 1'b1;
        cyc();
        srst = 1'b0;
        chk("srst_we", 32'(ram_we), 32'd0);
        chk("srst_hist_rdy", 32'(hist_rdy), 32'd1);
        chk("srst_tready", 32'(s_axis_tready), 32'd1);
        repeat (4) cyc();
        erase();
        open_frame();
        px(16'h800F, 1'b1, 1'b1);
        px(16'h800F, 1'b1, 1'b1);
        px(16'h8000, 1'b1, 1'b1);
        close_frame(3, 1'b0);
        want = '{default: 4'h0};
        want[15] = 4'd2;
        want[0]  = 4'd1;
        ram_check();

        repeat (5) cyc();
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("res_q_drained", 32'(res_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hist_calc_pipe.md
Name: hist_calc_pipe

Overview:
- Parametrised, fully pipelined histogram accumulator for the IR video path; successor to the single-bin-per-3-cycles calculator.
- Accepts one pixel per clock with read-modify-write hazard forwarding and saturating bin counters.
- Bins are selected from the top BIN_W bits of a PIX_W pixel, and a per-frame valid-pixel count is reported.
- Sits between the sensor-correction AXIS stream and the external histogram RAM consumed by the equalizer LUT builder.

Parameters:
- PIX_W, 14: pixel width in s_axis_tdata[PIX_W-1:0]; 1..15.
- BIN_W, 14: histogram address width; bin = pix[PIX_W-1 -: BIN_W]; BIN_W <= PIX_W.
- CNT_W, 18: bin counter width; counters saturate at 2^CNT_W-1.
- FCNT_W, 24: frame valid-pixel counter width; saturates.

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous reset, active-high.
- sof  in  1  start-of-frame pulse.
- hist_upd  in  1  request a new histogram (erase then collect one frame).
- hist_rdy  out  1  histogram complete and stable in RAM.
- frm_pix_cnt  out  FCNT_W  good pixels counted in the last collected frame.
- sat_flag  out  1  at least one bin saturated in the last frame.
- s_axis_tdata  in  16  bit15 = pixel good; [PIX_W-1:0] = pixel.
- s_axis_tvalid  in  1  AXIS valid.
- s_axis_tready  out  1  AXIS ready.
- s_axis_tlast  in  1  ignored (framing by sof).
- ram_rd_addr  out  BIN_W  read port address, registered.
- ram_rd_dout  in  CNT_W  read data; valid 1 cycle after ram_rd_addr presented.
- ram_we  out  1  write enable.
- ram_wr_addr  out  BIN_W  write address.
- ram_wr_din  out  CNT_W  write data.

Behaviour:
- RAM model: simple dual port, read latency 1, read-first. A write committed at the end of cycle t is visible to a read presented in cycle t+1 or later.
- Reset values:
  - hist_rdy=1, s_axis_tready=1, ram_we=0.
  - ram_rd_addr=0, ram_wr_addr=0, ram_wr_din=0.
  - frm_pix_cnt=0, sat_flag=0, pipeline valids=0, state=IDLE.
- IDLE:
  - tready=1; incoming pixels are discarded.
  - hist_upd -> hist_rdy<=0, ram_we<=1, wr_addr<=0, din<=0, go to ERASE.
- ERASE:
  - tready=0; write zero to addresses 0..2^BIN_W-1, one per cycle, 2^BIN_W write cycles total.
  - After the last address: ram_we<=0, go to WAIT_SOF. sof is ignored in this state.
- WAIT_SOF:
  - tready=1; pixels discarded.
  - On sof: clear the frame counter and sat accumulator, go to COLLECT.
  - A pixel handshaked in the same cycle as sof is discarded.
- COLLECT:
  - tready=1. Each handshake with bit15=1 enters the pipeline; bit15=0 pixels are consumed and not counted.
  - S0 (accept edge): rd_addr<=bin.
  - S1: RAM read in flight.
  - S2: cnt = forwarded value, else ram_rd_dout.
  - Forwarding: if bin equals the bin of a write issued at the S2 edge 1 or 2 cycles earlier, use the newest such written value instead of ram_rd_dout.
  - At the S2 edge: ram_we<=1, wr_addr<=bin, din <= (cnt==max) ? max : cnt+1. Saturation sets sat_flag.
  - frm_pix_cnt increments, saturating, on each good pixel at S2.
  - Pixel-to-write latency: 3 cycles. Sustained throughput: 1 pixel/clk, with any bin repetition pattern.
  - sof -> go to DRAIN. A pixel handshaked in the same cycle as sof is excluded.
- DRAIN:
  - tready=0 for 3 cycles while in-flight pixels complete; ram_we deasserts after the last write.
  - Then hist_rdy<=1 and frm_pix_cnt/sat_flag are published (held until the next hist_upd), go to IDLE.
- hist_upd outside IDLE is ignored; it must be re-requested.
- srst mid-operation: return to reset values immediately. In-flight writes are dropped and RAM contents are undefined until the next hist_upd.
- Arithmetic is unsigned; bin truncation takes the MSBs of the pixel.

Decomposition:
- hist_pkg: state encodings (IDLE, ERASE, WAIT_SOF, COLLECT, DRAIN), DRAIN_CYC=3, default widths, CNT_MAX function.
- Sub-module hist_fwd_inc: the S2 stage. Two-entry write-history compare/forward plus saturating increment, with ports bin, vld, ram_dout, we/addr/din out, sat.

Test Plan:
- Erase: BIN_W=4, CNT_W=4, RAM prefilled with 0xF; pulse hist_upd -> exactly 16 zero writes on consecutive cycles, addresses 0..15, tready=0 throughout, hist_rdy=0.
- Back-to-back same bin: 10 consecutive good pixels of value 0x3 (PIX_W=BIN_W=4) then sof -> RAM[3]=10, all others 0, frm_pix_cnt=10, hist_rdy=1 three cycles after DRAIN entry.
- Hazard patterns: sequence 5,6,5,5,6,7,5 at 1 pixel/clk -> RAM[5]=4, RAM[6]=2, RAM[7]=1, no stalls (tready stays 1).
- Saturation: CNT_W=4, 20 pixels to bin 2 -> RAM[2]=15, sat_flag=1, frm_pix_cnt=20.
- Filtering/framing:
  - bit15=0 pixels are not counted.
  - Pixels on the opening-sof cycle, closing-sof cycle and in WAIT_SOF are not counted.
  - tvalid gaps are tolerated.
  - Expected: the counted total equals the number of good mid-frame pixels only.
- Reset mid-COLLECT: assert srst with 2 pixels in flight -> next cycle ram_we=0, hist_rdy=1, tready=1, state IDLE; a new hist_upd completes normally.
